tone_player: RTL and testbench
==============================

// Module: tone_player
// PURPOSE
//  Parametrised successor to the speaker divider. Accepts one note (tone word + duration) per
//  valid/ready handshake and plays it on the speaker output for a set number of beat ticks.
//  Each note is followed by a programmable silent gap, then a one-cycle done pulse.
//  Sits between the music sequencer (note source, beat time-base) and the speaker pin.
// PARAMETERS
//  CNT_W      11  tone divider width; SPKS period = 2^CNT_W - tn cycles
//  DUR_W       8  duration field width, in beat ticks
//  GAP_TICKS   1  silent beat ticks after each note (0 = no gap)
// PORTS
//  CLK         in   1      system clock
//  RST         in   1      asynchronous, active-low reset
//  tick_en     in   1      beat strobe, one CLK wide
//  abort       in   1      synchronous stop of the current note
//  note_valid  in   1      note offered
//  note_ready  out  1      note accepted when valid&ready (high only in IDLE)
//  note_tn     in   CNT_W  divider preload; 0 = rest (silence), lowest pitch is tn=1
//  note_dur    in   DUR_W  note length in beat ticks
//  SPKS        out  1      one-cycle pulse per divider overflow (legacy pulse output)
//  SPK         out  1      square wave, toggles on every overflow (50% duty)
//  busy        out  1      high in PLAY and GAP
//  done        out  1      one-cycle pulse when a note (incl. gap) completes normally
// BEHAVIOUR
//  Reset (RST low, async): state IDLE, divider/duration counters 0, SPKS=SPK=busy=done=0,
//   note_ready=1. Reset mid-note drops the note with no done pulse.
//  All outputs registered except note_ready, decoded from state (IDLE).
//  FSM states IDLE, PLAY, GAP:
//   IDLE: on valid&ready at edge k: latch tn, load dur counter with note_dur, load divider
//    with note_tn, SPK phase cleared to 0. dur!=0 -> PLAY; dur==0 -> GAP (or IDLE with done
//    if GAP_TICKS==0). note_valid outside IDLE is ignored (not accepted, not queued).
//   PLAY: divider increments each CLK; when divider==all-ones the next edge reloads tn,
//    sets SPKS=1 for that cycle and toggles SPK; otherwise SPKS=0. Each tick_en decrements
//    dur counter; tick_en with counter==1 -> GAP (GAP_TICKS>0) or IDLE+done. PLAY spans
//    exactly note_dur tick_en strobes; a tick coincident with the accept edge is not counted.
//   GAP: SPK=SPKS=0, divider held; counts GAP_TICKS tick_en strobes, then IDLE with done=1
//    in the first IDLE cycle.
//  Rest (tn==0): full FSM timing kept, divider held, SPK=SPKS=0 throughout.
//  tn=all-ones: SPKS high every cycle in PLAY, SPK toggles every cycle (legal, max pitch).
//  abort (any state): next edge -> IDLE, SPK=SPKS=0, done not asserted; abort in IDLE
//   has no effect; abort has priority over a simultaneous tick_en or accept.
//  Latency: accept edge to first SPKS = 2^CNT_W - tn cycles; at least one IDLE cycle
//   (note_ready high) between consecutive notes.
//  Widths: divider and dur counters wrap-free by construction (reload/stop at limits).
// TESTING
//  1. tn=0x7FB, dur=2, tick every 100 clk -> SPKS every 5 clk, first 5 clk after accept;
//     SPK period 10 clk; SPK low at start.
//  2. dur=3, GAP_TICKS=1 -> busy for 3 ticks PLAY + 1 tick GAP; done one cycle; note_ready
//     returns 1 in same cycle as done.
//  3. tn=0 rest, dur=2 -> SPK=SPKS=0 throughout, done after 2+1 ticks as in scenario 2.
//  4. dur=0, GAP_TICKS=0 -> done 1 cycle after accept, no SPKS pulse ever.
//  5. abort mid-PLAY with simultaneous tick_en -> IDLE next edge, SPK=0, no done; new
//     note_valid with note_ready=1 accepted following cycle.
//  6. RST low mid-PLAY (async, between edges) -> SPK/SPKS/busy 0 immediately, note_ready 1;
//     after release, note_valid held during PLAY of a new note is not accepted until IDLE.

Source files
------------

// File: rtl/tone_player.sv
// tone_player
//   Plays one note per valid/ready handshake on the speaker pin. The note's
//   tone word sets the divider preload, and its duration sets the number of
//   beat ticks it lasts. After each note comes a programmable silent gap and
//   then a one-cycle done pulse.
//
//   State table:
//     state  | meaning
//     IDLE   | waiting for a note; note_ready high
//     PLAY   | divider running; one beat tick consumed per tick_en
//     GAP    | silent; counting GAP_TICKS beat ticks before done
//
// Ports:
//   CLK, RST     clock and asynchronous active-low reset
//   tick_en      beat strobe, one CLK wide
//   abort        synchronous stop of the current note (no done pulse)
//   note_valid   note offered; accepted when note_ready is also high
//   note_ready   high only in IDLE
//   note_tn      divider preload (0 = rest)
//   note_dur     note length in beat ticks
//   SPKS         one-cycle pulse per divider overflow
//   SPK          square wave that toggles on every overflow
//   busy         high in PLAY and GAP
//   done         one-cycle pulse when a note and its gap complete
module tone_player #(
  parameter int CNT_W     = 11,
  parameter int DUR_W     = 8,
  parameter int GAP_TICKS = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             tick_en,
  input  logic             abort,
  input  logic             note_valid,
  output logic             note_ready,
  input  logic [CNT_W-1:0] note_tn,
  input  logic [DUR_W-1:0] note_dur,
  output logic             SPKS,
  output logic             SPK,
  output logic             busy,
  output logic             done
);

  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LD = GAP_W'(GAP_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_done_nxt;
  logic               w_play_run;
  logic [CNT_W-1:0]   r_tn;
  logic [CNT_W-1:0]   r_div;
  logic [DUR_W-1:0]   r_dur;
  logic [GAP_W-1:0]   r_gap;
  logic               r_spks;
  logic               r_spk;
  logic               r_busy;
  logic               r_done;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // abort is checked first in every state so it wins over tick_en and accept.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (note_valid && !abort) begin
          w_accept = 1'b1;
          if (note_dur != '0)      w_state_nxt = S_PLAY;
          else if (GAP_TICKS != 0) w_state_nxt = S_GAP;
          else                     w_done_nxt  = 1'b1;
        end
      end
      S_PLAY: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (tick_en && (r_dur == DUR_W'(1))) begin
          if (GAP_TICKS != 0) begin
            w_state_nxt = S_GAP;
          end else begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (tick_en && (r_gap == GAP_W'(1))) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_play_run = (r_state == S_PLAY) && (w_state_nxt == S_PLAY);
  end

  // Speaker outputs are only driven while staying in PLAY; any exit from
  // PLAY (end of note, abort) forces them low on the same edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_tn   <= '0;
      r_div  <= '0;
      r_dur  <= '0;
      r_gap  <= '0;
      r_spks <= 1'b0;
      r_spk  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_accept) begin
        r_tn   <= note_tn;
        r_div  <= note_tn;
        r_dur  <= note_dur;
        r_spks <= 1'b0;
        r_spk  <= 1'b0;
      end else if (w_play_run) begin
        if (tick_en) r_dur <= r_dur - DUR_W'(1);
        if (r_tn == '0) begin
          r_spks <= 1'b0;
          r_spk  <= 1'b0;
        end else if (r_div == '1) begin
          r_div  <= r_tn;
          r_spks <= 1'b1;
          r_spk  <= ~r_spk;
        end else begin
          r_div  <= r_div + CNT_W'(1);
          r_spks <= 1'b0;
        end
      end else begin
        r_spks <= 1'b0;
        r_spk  <= 1'b0;
      end
      // Gap counter is preloaded whenever not in GAP, so it is ready on entry.
      if (r_state != S_GAP) r_gap <= GAP_LD;
      else if (tick_en)     r_gap <= r_gap - GAP_W'(1);
    end
  end

  assign note_ready = (r_state == S_IDLE);
  assign SPKS       = r_spks;
  assign SPK        = r_spk;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule

// File: tb/tb_tone_player.sv
// Scoreboard bench for tone_player. Two instances share one stimulus stream:
// u_dut1 with a one-tick gap and u_dut2 with no gap. For every accepted note
// the reference model works out, from the precomputed beat-tick schedule,
// the cycles of every SPKS pulse, the end of PLAY, the end of the gap and the
// done pulse, and pushes them into queues; the monitor pops them on the
// opposite clock edge.
module tb_tone_player;
  localparam int CNT_W = 11;
  localparam int DUR_W = 8;
  localparam int FULL  = 1 << CNT_W;
  localparam int NT    = 20000;
  localparam int NOTES = 40;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             tick_en = 1'b0;
  logic             abort = 1'b0;
  logic             note_valid = 1'b0;
  logic [CNT_W-1:0] note_tn = '0;
  logic [DUR_W-1:0] note_dur = '0;
  logic rdy1, spks1, spk1, busy1, done1;
  logic rdy2, spks2, spk2, busy2, done2;

  tone_player #(.CNT_W(CNT_W), .DUR_W(DUR_W), .GAP_TICKS(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .tick_en(tick_en), .abort(abort),
    .note_valid(note_valid), .note_ready(rdy1), .note_tn(note_tn),
    .note_dur(note_dur), .SPKS(spks1), .SPK(spk1), .busy(busy1), .done(done1));

  tone_player #(.CNT_W(CNT_W), .DUR_W(DUR_W), .GAP_TICKS(0)) u_dut2 (
    .CLK(CLK), .RST(RST), .tick_en(tick_en), .abort(abort),
    .note_valid(note_valid), .note_ready(rdy2), .note_tn(note_tn),
    .note_dur(note_dur), .SPKS(spks2), .SPK(spk2), .busy(busy2), .done(done2));

  always #5 CLK = ~CLK;

  // cyc = number of rising edges seen; inputs for edge n are driven after edge n-1.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  bit tick_at[NT];

  typedef struct {
    int cyc;
    bit spk;
  } ev_t;

  ev_t q_s1[$];
  ev_t q_s2[$];
  int  q_d1[$];
  int  q_d2[$];
  int  m_start = 0;
  int  m_pend  = 0;
  int  m_end1  = 0;
  int  m_end2  = 0;
  bit  last1, last2;
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < NT; i++) tick_at[i] = ($urandom_range(0, 24) == 0);
    forever begin
      @(posedge CLK);
      #1;
      tick_en = (cyc + 1 < NT) ? tick_at[cyc + 1] : 1'b0;
    end
  end

  always @(negedge CLK) begin : mon
    bit es, ed, in_play, b1, b2;
    if (RST) begin
      if (cyc == m_start) begin
        last1 = 1'b0;
        last2 = 1'b0;
      end
      in_play = (cyc >= m_start) && (cyc < m_pend);
      b1 = (cyc >= m_start) && (cyc < m_end1);
      b2 = (cyc >= m_start) && (cyc < m_end2);

      es = (q_s1.size() > 0) && (q_s1[0].cyc == cyc);
      if (es) begin last1 = q_s1[0].spk; void'(q_s1.pop_front()); end
      chk("spks1", spks1, es);
      chk("spk1", spk1, in_play ? last1 : 1'b0);
      ed = (q_d1.size() > 0) && (q_d1[0] == cyc);
      if (ed) void'(q_d1.pop_front());
      chk("done1", done1, ed);
      chk("busy1", busy1, b1);
      chk("ready1", rdy1, !b1);

      es = (q_s2.size() > 0) && (q_s2[0].cyc == cyc);
      if (es) begin last2 = q_s2[0].spk; void'(q_s2.pop_front()); end
      chk("spks2", spks2, es);
      chk("spk2", spk2, in_play ? last2 : 1'b0);
      ed = (q_d2.size() > 0) && (q_d2[0] == cyc);
      if (ed) void'(q_d2.pop_front());
      chk("done2", done2, ed);
      chk("busy2", busy2, b2);
      chk("ready2", rdy2, !b2);
    end
  end

  function automatic int imin(input int x, input int y);
    return (x < y) ? x : y;
  endfunction

  // Abort taking effect at edge b: nothing predicted at or after b happens.
  task automatic truncate(input int b);
    while (q_s1.size() > 0 && q_s1[$].cyc >= b) void'(q_s1.pop_back());
    while (q_s2.size() > 0 && q_s2[$].cyc >= b) void'(q_s2.pop_back());
    while (q_d1.size() > 0 && q_d1[$] >= b) void'(q_d1.pop_back());
    while (q_d2.size() > 0 && q_d2[$] >= b) void'(q_d2.pop_back());
    m_pend = imin(m_pend, b);
    m_end1 = imin(m_end1, b);
    m_end2 = imin(m_end2, b);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_spks1", spks1, 0);
    chk("rst_spk1", spk1, 0);
    chk("rst_busy1", busy1, 0);
    chk("rst_ready1", rdy1, 1);
    chk("rst_spks2", spks2, 0);
    chk("rst_spk2", spk2, 0);
    chk("rst_busy2", busy2, 0);
    chk("rst_ready2", rdy2, 1);
    q_s1.delete();
    q_s2.delete();
    q_d1.delete();
    q_d2.delete();
    m_pend = cyc;
    m_end1 = cyc;
    m_end2 = cyc;
    @(posedge CLK);
    #1;
    RST = 1'b1;
  endtask

  // act: 0 none, 1 abort on first tick in PLAY, 2 reset mid-PLAY, 3 random abort
  task automatic pick(input int i, output int tn, output int dur,
                      output int act, output int idle);
    case (i)
      0: begin tn = 'h7FB; dur = 2; act = 0; idle = 2; end
      1: begin tn = 'h7F0; dur = 3; act = 0; idle = 1; end
      2: begin tn = 0;     dur = 2; act = 0; idle = 0; end
      3: begin tn = 'h7FF; dur = 0; act = 0; idle = 1; end
      4: begin tn = 'h7FF; dur = 2; act = 1; idle = 0; end
      5: begin tn = 'h7FA; dur = 3; act = 2; idle = 0; end
      default: begin
        case ($urandom_range(0, 5))
          0:       tn = 0;
          1:       tn = FULL - 1;
          default: tn = FULL - $urandom_range(2, 40);
        endcase
        dur  = $urandom_range(0, 5);
        act  = ($urandom_range(0, 14) == 0) ? 2 : 3;
        idle = $urandom_range(0, 3);
      end
    endcase
  endtask

  initial begin : stim
    int a, e, g, t, cnt, b, p, m, n1, end_edge;
    int tn, dur, act, idle;
    bit do_ab, do_rst;
    ev_t ev;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_ready1", rdy1, 1);
    chk("reset_busy1", busy1, 0);
    RST = 1'b1;
    for (int i = 0; i < NOTES && cyc < NT - 2000; i++) begin
      pick(i, tn, dur, act, idle);
      for (int k = 0; k < idle; k++) begin
        note_valid = 1'b0;
        abort = ($urandom_range(0, 2) == 0);
        @(posedge CLK);
        #1;
      end
      abort      = 1'b0;
      a          = cyc + 1;
      note_valid = 1'b1;
      note_tn    = CNT_W'(tn);
      note_dur   = DUR_W'(dur);

      // End of PLAY: the dur-th tick strictly after the accept edge.
      t = a; cnt = 0;
      while (cnt < dur && t < NT - 1) begin t++; if (tick_at[t]) cnt++; end
      e = t;
      // End of the one-tick gap: next tick strictly after e.
      cnt = 0;
      while (cnt < 1 && t < NT - 1) begin t++; if (tick_at[t]) cnt++; end
      g = t;
      if (tn != 0) begin
        p = FULL - tn;
        m = 1;
        for (int c = a + p; c < e; c += p) begin
          ev = '{c, m[0]};
          q_s1.push_back(ev);
          q_s2.push_back(ev);
          m++;
        end
      end
      q_d1.push_back(g);
      q_d2.push_back(e);
      m_start = a;
      m_pend  = e;
      m_end1  = g;
      m_end2  = e;

      do_ab = 1'b0; do_rst = 1'b0; b = 0;
      if (act == 1) begin
        t = a + 1;
        while (!tick_at[t] && t < g) t++;
        b = t; do_ab = 1'b1;
      end else if (act == 2 && e > a) begin
        b = a + 1 + $urandom_range(0, e - a - 1); do_rst = 1'b1;
      end else if (act == 3 && g > a + 1 && $urandom_range(0, 3) == 0) begin
        b = $urandom_range(a + 1, g); do_ab = 1'b1;
      end
      end_edge = (do_ab || do_rst) ? b : g;

      forever begin
        @(posedge CLK);
        #1;
        n1 = cyc + 1;
        abort = 1'b0;
        note_valid = 1'b0;
        if (n1 > end_edge) break;
        if (do_rst && n1 == b) begin do_reset(); break; end
        if (do_ab && n1 == b) begin abort = 1'b1; truncate(b); end
        // Offers while busy must be ignored by both instances.
        if (n1 <= e && $urandom_range(0, 1) == 1) begin
          note_valid = 1'b1;
          note_tn    = CNT_W'($urandom);
          note_dur   = DUR_W'($urandom);
        end
      end
    end
    note_valid = 1'b0;
    abort = 1'b0;
    repeat (10) @(posedge CLK);
    #1;
    chk("left_spks1", q_s1.size(), 0);
    chk("left_spks2", q_s2.size(), 0);
    chk("left_done1", q_d1.size(), 0);
    chk("left_done2", q_d2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
    $fatal(1, "time limit");
  end

endmodule
